// File: rtl/exmem_pkg.sv
// Shared widths, payload layout and skid-buffer occupancy encoding for the EX/MEM stage.
package exmem_pkg;

    localparam int DATA_W       = 32;
    localparam int REG_W        = 5;
    localparam int WB_W         = 3;
    localparam int M_W          = 3;
    localparam int REGWRITE_BIT = 0;
    localparam int CNT_W        = 16;

    typedef struct packed {
        logic [WB_W-1:0]   wb;
        logic [M_W-1:0]    m;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] pcplus;
        logic [REG_W-1:0]  rd;
    } exmem_bundle_t;

    localparam int BUNDLE_W = $bits(exmem_bundle_t);

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/exmem_skid_stage_if.sv
// EX-side and MEM-side handshake bundle of the EX/MEM stage, plus its observation taps.
interface exmem_skid_stage_if #(
    parameter int DATA_W = exmem_pkg::DATA_W,
    parameter int REG_W  = exmem_pkg::REG_W,
    parameter int WB_W   = exmem_pkg::WB_W,
    parameter int M_W    = exmem_pkg::M_W,
    parameter int CNT_W  = exmem_pkg::CNT_W
);
    import exmem_pkg::*;

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [WB_W-1:0]   in_wb;
    logic [M_W-1:0]    in_m;
    logic [DATA_W-1:0] in_alu;
    logic [DATA_W-1:0] in_wdata;
    logic [DATA_W-1:0] in_pcplus;
    logic [REG_W-1:0]  in_rd;
    logic              out_valid;
    logic              out_ready;
    logic [WB_W-1:0]   out_wb;
    logic [M_W-1:0]    out_m;
    logic [DATA_W-1:0] out_alu;
    logic [DATA_W-1:0] out_wdata;
    logic [DATA_W-1:0] out_pcplus;
    logic [REG_W-1:0]  out_rd;
    logic              fwd_en;
    logic [REG_W-1:0]  fwd_rd;
    logic [DATA_W-1:0] fwd_data;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output flush, in_valid, in_wb, in_m, in_alu, in_wdata, in_pcplus, in_rd, out_ready,
        input  in_ready, out_valid, out_wb, out_m, out_alu, out_wdata, out_pcplus, out_rd,
        input  fwd_en, fwd_rd, fwd_data, stall_cnt
    );

    modport slave (
        input  flush, in_valid, in_wb, in_m, in_alu, in_wdata, in_pcplus, in_rd, out_ready,
        output in_ready, out_valid, out_wb, out_m, out_alu, out_wdata, out_pcplus, out_rd,
        output fwd_en, fwd_rd, fwd_data, stall_cnt
    );

endinterface

// File: rtl/skid_buf.sv
// Two-entry elastic buffer (main + skid) with registered in_ready and synchronous clear.
module skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    import exmem_pkg::*;

    buf_state_e state, state_nxt;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         load_main;
    logic         main_from_skid;
    logic         load_skid;
    logic         accept;
    logic         consume;

    // in_ready depends only on the state register, so no stall path reaches EX combinationally.
    assign in_ready  = (state != BUF_TWO);
    assign out_valid = (state != BUF_EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BUF_EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        if (clr) begin
            state_nxt = BUF_EMPTY;
        end else begin
            case (state)
                BUF_EMPTY: if (accept) begin
                    load_main = 1'b1;
                    state_nxt = BUF_ONE;
                end
                BUF_ONE: begin
                    if (consume && accept) begin
                        load_main = 1'b1;
                    end else if (consume) begin
                        state_nxt = BUF_EMPTY;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_nxt = BUF_TWO;
                    end
                end
                BUF_TWO: if (consume) begin
                    main_from_skid = 1'b1;
                    state_nxt      = BUF_ONE;
                end
                default: state_nxt = BUF_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              main_q <= '0;
        else if (main_from_skid) main_q <= skid_q;
        else if (load_main)      main_q <= in_data;
    end

    always_ff @(posedge clk) begin
        if (load_skid) skid_q <= in_data;
    end

endmodule

// File: rtl/exmem_skid_stage.sv
// EX/MEM elastic pipeline stage: skid buffer plus flush, NOP-gated control, WB forwarding tap and stall counter.
module exmem_skid_stage #(
    parameter int DATA_W       = exmem_pkg::DATA_W,
    parameter int REG_W        = exmem_pkg::REG_W,
    parameter int WB_W         = exmem_pkg::WB_W,
    parameter int M_W          = exmem_pkg::M_W,
    parameter int REGWRITE_BIT = exmem_pkg::REGWRITE_BIT,
    parameter int CNT_W        = exmem_pkg::CNT_W
) (
    input logic               clk,
    input logic               rst_n,
    exmem_skid_stage_if.slave bus
);
    import exmem_pkg::*;

    localparam int W = WB_W + M_W + 3 * DATA_W + REG_W;

    logic [W-1:0]      in_payload;
    logic [W-1:0]      out_payload;
    logic              vld;
    logic [WB_W-1:0]   wb_raw;
    logic [M_W-1:0]    m_raw;
    logic [DATA_W-1:0] alu_raw;
    logic [DATA_W-1:0] wdata_raw;
    logic [DATA_W-1:0] pcplus_raw;
    logic [REG_W-1:0]  rd_raw;
    logic [CNT_W-1:0]  stall_cnt_q;

    assign in_payload = {bus.in_wb, bus.in_m, bus.in_alu, bus.in_wdata, bus.in_pcplus, bus.in_rd};

    skid_buf #(.W(W)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (bus.flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (in_payload),
        .out_valid (vld),
        .out_ready (bus.out_ready),
        .out_data  (out_payload)
    );

    assign {wb_raw, m_raw, alu_raw, wdata_raw, pcplus_raw, rd_raw} = out_payload;

    // Control fields read as a NOP whenever no bundle is presented to MEM.
    assign bus.out_valid  = vld;
    assign bus.out_wb     = vld ? wb_raw : '0;
    assign bus.out_m      = vld ? m_raw  : '0;
    assign bus.out_alu    = alu_raw;
    assign bus.out_wdata  = wdata_raw;
    assign bus.out_pcplus = pcplus_raw;
    assign bus.out_rd     = rd_raw;

    assign bus.fwd_en   = vld & wb_raw[REGWRITE_BIT];
    assign bus.fwd_rd   = rd_raw;
    assign bus.fwd_data = alu_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_q <= '0;
        else if (vld && !bus.out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_q <= stall_cnt_q + 1'b1;
    end

    assign bus.stall_cnt = stall_cnt_q;

endmodule
